hbridge_burst_gen: RTL and testbench
====================================

Name: hbridge_burst_gen

Overview:
- Parametrised successor to the single-bridge transducer driver.
- Generates a finite burst of bipolar square-wave cycles on NUM_CH H-bridges with programmable half-period, cycle count and channel mask.
- Enforces dead time between every polarity change and drives the TX/RX switch for the duration of the burst.
- Sits between the I2C-configured control registers and the bridge gate pins in the DVL top level.

Parameters:
NUM_CH, 2, number of H-bridges driven in lockstep
PERIOD_W, 16, width of half_period input
CYC_W, 8, width of num_cycles input
DEAD_CYCLES, 2, clocks all four gates off between phases (legal range >=1)
DAMP_CYCLES, 32, low-side brake length (used only with HB_DAMP_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle request; sampled only in IDLE
abort  input  1  synchronous abort; highest priority after rst
half_period  input  PERIOD_W  clocks per drive phase; latched on start
num_cycles  input  CYC_W  full bipolar cycles per burst; latched on start
ch_mask  input  NUM_CH  per-channel enable; latched on start
hlh  output  NUM_CH  left high-side gate
hll  output  NUM_CH  left low-side gate
hrh  output  NUM_CH  right high-side gate
hrl  output  NUM_CH  right low-side gate
txrx  output  1  1 = transmit path selected, 0 = receive
busy  output  1  burst in progress
done  output  1  one-cycle pulse at end of burst or abort
aborted  output  1  valid with done; 1 if the burst ended by abort

Behaviour:
- Clock and reset: one clock. rst is asynchronous and active-high. In reset, every output is 0 and the state is IDLE.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, DEAD, PHASE_A, PHASE_B, DAMP, DONE.
- IDLE:
  - On start=1, latch half_period, num_cycles and ch_mask.
  - half_period=0 is clamped to 1.
  - num_cycles=0: go to DONE directly. No gate activity; txrx stays 0.
  - Otherwise go to DEAD. txrx=1 and busy=1 from the first DEAD cycle.
- DEAD: all gates 0 for DEAD_CYCLES clocks. Next state is PHASE_A, PHASE_B or end-of-burst, chosen by the phase that preceded it.
- PHASE_A: for latched half_period clocks, hlh=hrl=mask and hll=hrh=0.
- PHASE_B: for latched half_period clocks, hrh=hll=mask and hlh=hrl=0.
- Burst sequence: DEAD, A, DEAD, B, repeated num_cycles times, then one trailing DEAD, then DAMP (if enabled), then DONE.
- Busy length without damping: num_cycles*2*(DEAD_CYCLES+half_period) + DEAD_CYCLES clocks.
- Cycle counter: CYC_W bits, decrements after each PHASE_B. It never wraps; the burst ends when it reaches 0.
- DONE (one clock):
  - done=1, busy=0, txrx=0; return to IDLE.
  - start in the DONE cycle is ignored.
- Shoot-through invariant: on every channel, in every cycle, hlh&hll=0 and hrh&hrl=0.
- Masking: a channel with mask=0 keeps all four of its gates at 0 throughout the burst.
- start while busy: ignored. The latched configuration is not altered.
- abort while busy:
  - Next clock: all gates 0 and txrx=0.
  - Then DONE with aborted=1.
  - Gates are forced off without dead time, because turning gates off is always safe.
- abort in IDLE: ignored, no done.
- abort and start in the same cycle in IDLE: abort wins, nothing happens.
- Reset mid-burst: all gates are released immediately (asynchronous). No done is produced.

Optional Feature:
- Macro HB_DAMP_EN.
- Defined: after the trailing DEAD, enter DAMP for DAMP_CYCLES clocks.
  - In DAMP, hll=hrl=mask and hlh=hrh=0, braking transducer ring-down.
  - txrx stays 1 through DAMP.
  - abort during DAMP behaves as abort mid-burst.
- Not defined: DAMP does not exist; the trailing DEAD goes straight to DONE. DAMP_CYCLES is unused.

Test Plan:
- Basic burst: DEAD_CYCLES=2, half_period=4, num_cycles=2, ch_mask=2'b11, no damp.
  - busy=1 and txrx=1 for exactly 26 clocks.
  - Pattern: 2 off, 4 A, 2 off, 4 B, repeated, then 2 off.
  - done pulses once; aborted=0.
- Mask and clamp: ch_mask=2'b01, half_period=0, num_cycles=1.
  - Channel 1 gates stay 0.
  - Channel 0 phases last 1 clock each; busy lasts 2*(2+1)+2=8 clocks.
- Zero cycles: num_cycles=0 -> done the following cycle; all gates and txrx stay 0 throughout.
- Abort: half_period=100, num_cycles=10, abort asserted on clock 50 of the burst.
  - Next clock: all gates 0 and txrx=0.
  - Then done=1 with aborted=1.
  - A start asserted during the burst had no effect.
- Damp (HB_DAMP_EN, DAMP_CYCLES=32): same stimulus as the basic burst.
  - Busy lasts 58 clocks; the final 32 have hll=hrl=2'b11.
- Continuous checker on all tests: no shoot-through. Asynchronous rst mid-phase forces every output to 0 within the same cycle.

Source files
------------

// File: rtl/hbridge_burst_gen.sv
// Burst generator for NUM_CH H-bridges: dead-time separated bipolar square-wave cycles plus TX/RX
// switch control. Optional low-side ring-down brake is enabled by defining HB_DAMP_EN.
module hbridge_burst_gen #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned PERIOD_W    = 16,
    parameter int unsigned CYC_W       = 8,
    parameter int unsigned DEAD_CYCLES = 2,
    parameter int unsigned DAMP_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] half_period,
    input  logic [CYC_W-1:0]    num_cycles,
    input  logic [NUM_CH-1:0]   ch_mask,
    output logic [NUM_CH-1:0]   hlh,
    output logic [NUM_CH-1:0]   hll,
    output logic [NUM_CH-1:0]   hrh,
    output logic [NUM_CH-1:0]   hrl,
    output logic                txrx,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    localparam int unsigned TW = (PERIOD_W > 16) ? PERIOD_W : 16;
    localparam logic [TW-1:0] DEAD_LOAD = TW'(DEAD_CYCLES - 1);
    localparam logic [TW-1:0] DAMP_LOAD = TW'(DAMP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StDead, StPhaseA, StPhaseB, StDamp, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [PERIOD_W-1:0] hp_q, hp_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                from_a_q, from_a_d;
    logic                abort_q, abort_d;
    logic                in_burst_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            cyc_q    <= '0;
            hp_q     <= '0;
            mask_q   <= '0;
            from_a_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cyc_q    <= cyc_d;
            hp_q     <= hp_d;
            mask_q   <= mask_d;
            from_a_q <= from_a_d;
            abort_q  <= abort_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        cyc_d    = cyc_q;
        hp_d     = hp_q;
        mask_d   = mask_q;
        from_a_d = from_a_q;
        abort_d  = abort_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    hp_d     = (half_period == '0) ? PERIOD_W'(1) : half_period;
                    cyc_d    = num_cycles;
                    mask_d   = ch_mask;
                    abort_d  = 1'b0;
                    from_a_d = 1'b0;
                    timer_d  = DEAD_LOAD;
                    state_d  = (num_cycles == '0) ? StDone : StDead;
                end
            end
            StDead: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (from_a_q) begin
                    state_d = StPhaseB;
                    timer_d = TW'(hp_q) - TW'(1);
                end else if (cyc_q != '0) begin
                    state_d = StPhaseA;
                    timer_d = TW'(hp_q) - TW'(1);
                end else begin
                    // Trailing dead time finished: brake if built in, else finish.
                    timer_d = DAMP_LOAD;
`ifdef HB_DAMP_EN
                    state_d = StDamp;
`else
                    state_d = StDone;
`endif
                end
            end
            StPhaseA: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    state_d  = StDead;
                    from_a_d = 1'b1;
                    timer_d  = DEAD_LOAD;
                end
            end
            StPhaseB: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    state_d  = StDead;
                    from_a_d = 1'b0;
                    cyc_d    = cyc_q - CYC_W'(1);
                    timer_d  = DEAD_LOAD;
                end
            end
            StDamp: begin
                if (timer_q != '0) timer_d = timer_q - TW'(1);
                else               state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Gates go off immediately on abort; no dead time needed to turn everything off.
        if (abort && (state_q inside {StDead, StPhaseA, StPhaseB, StDamp})) begin
            state_d = StDone;
            abort_d = 1'b1;
        end
    end

    assign in_burst_d = state_d inside {StDead, StPhaseA, StPhaseB, StDamp};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hlh     <= '0;
            hll     <= '0;
            hrh     <= '0;
            hrl     <= '0;
            txrx    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            hlh     <= (state_d == StPhaseA) ? mask_d : '0;
            hrl     <= (state_d inside {StPhaseA, StDamp}) ? mask_d : '0;
            hrh     <= (state_d == StPhaseB) ? mask_d : '0;
            hll     <= (state_d inside {StPhaseB, StDamp}) ? mask_d : '0;
            txrx    <= in_burst_d;
            busy    <= in_burst_d;
            done    <= (state_d == StDone);
            aborted <= (state_d == StDone) && abort_d;
        end
    end

endmodule

// File: tb/tb_hbridge_burst_gen.sv
// Directed bench for hbridge_burst_gen (default parameters); damp test is active with HB_DAMP_EN.
module tb_hbridge_burst_gen;

    localparam int DEAD = 2;
`ifdef HB_DAMP_EN
    localparam int DAMP = 32;
`else
    localparam int DAMP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] half_period;
    logic [7:0]  num_cycles;
    logic [1:0]  ch_mask;
    logic [1:0]  hlh, hll, hrh, hrl;
    logic        txrx, busy, done, aborted;

    int checks   = 0;
    int failures = 0;

    hbridge_burst_gen dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .half_period (half_period),
        .num_cycles  (num_cycles),
        .ch_mask     (ch_mask),
        .hlh         (hlh),
        .hll         (hll),
        .hrh         (hrh),
        .hrl         (hrl),
        .txrx        (txrx),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs();
        return {20'd0, busy, txrx, done, aborted, hlh, hll, hrh, hrl};
    endfunction

    // Shoot-through watchdog on every cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) check("shoot", {30'd0, (hlh & hll) | (hrh & hrl)}, 32'd0);
    end

    // Runs one burst, comparing every cycle against a pattern built from the burst parameters.
    // abort_at: burst cycle after which abort is raised (-1 none); ign_at: cycle to pulse start.
    task automatic burst(input string tag, input int hp_in, input int nc, input logic [1:0] m,
                         input int abort_at, input int ign_at);
        int hp, per, core, blen, last, pos;
        logic [1:0] ehlh, ehll, ehrh, ehrl;
        logic eb, ed, ea;
        hp   = (hp_in == 0) ? 1 : hp_in;
        per  = 2 * (DEAD + hp);
        core = nc * per + DEAD;
        blen = (nc == 0) ? 0 : core + DAMP;
        last = (abort_at >= 0) ? abort_at + 2 : blen + 1;
        half_period = 16'(hp_in);
        num_cycles  = 8'(nc);
        ch_mask     = m;
        start       = 1'b1;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            {ehlh, ehll, ehrh, ehrl} = '0;
            eb = 1'b0; ed = 1'b0; ea = 1'b0;
            if (abort_at >= 0 && i > abort_at) begin
                if (i == abort_at + 1) begin ed = 1'b1; ea = 1'b1; end
            end else if (i < blen) begin
                eb  = 1'b1;
                pos = i % per;
                if (i >= nc * per) begin
                    if (i >= core) begin ehll = m; ehrl = m; end
                end else if (pos >= DEAD && pos < DEAD + hp) begin
                    ehlh = m; ehrl = m;
                end else if (pos >= 2 * DEAD + hp) begin
                    ehrh = m; ehll = m;
                end
            end else if (i == blen) begin
                ed = 1'b1;
            end
            check($sformatf("%s[%0d]", tag, i), obs(),
                  {20'd0, eb, eb, ed, ea, ehlh, ehll, ehrh, ehrl});
            abort = (i == abort_at);
            start = (i == ign_at);
            if (i == ign_at) begin
                half_period = 16'd3;
                num_cycles  = 8'd1;
                ch_mask     = 2'b10;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        half_period = '0; num_cycles = '0; ch_mask = '0;
        #12;
        check("reset_outputs", obs(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", obs(), 32'd0);

        // Basic burst; start pulsed in the DONE cycle (26 + DAMP) must be ignored.
        burst("basic", 4, 2, 2'b11, -1, 26 + DAMP);
        // Mask and half_period clamp: 8 busy clocks (plus DAMP), channel 1 idle.
        burst("mask_clamp", 0, 1, 2'b01, -1, -1);
        // Zero cycles: DONE next cycle, nothing driven.
        burst("zero_cyc", 5, 0, 2'b11, -1, -1);
        // Abort on burst clock 50 with an ignored start earlier in the burst.
        burst("abort", 100, 10, 2'b11, 49, 20);

        // abort alone in IDLE, then abort together with start: nothing happens.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        check("idle_abort", obs(), 32'd0);
        start = 1'b1; half_period = 16'd4; num_cycles = 8'd2; ch_mask = 2'b11;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_0", obs(), 32'd0);
        @(negedge clk);
        check("abort_start_1", obs(), 32'd0);

        // Asynchronous reset while in PHASE_A releases everything within the cycle.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_phase_a", {30'd0, hlh}, 32'd3);
        #2 rst = 1'b1;
        #1 check("async_rst", obs(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst[%0d]", i), obs(), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
